// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: N-master arbiter in front of the SDRAM controller.
// Picks one requesting master per sdram_ready cycle (fixed priority or round-robin,
// with starvation override), registers its request toward the controller, and
// routes read beats / burst-complete back to the owning master by ID.
// Ports:
//   clk, reset (async, active-low)
//   m_request/m_write/m_burst/m_address/m_wdata/m_wstrb : per-master request (packed)
//   m_ready      : same-cycle grant strobe, one-hot or zero
//   m_rvalid/m_complete/m_raddress/m_rdata : combinational return path
//   sdram_request..sdram_wdata : registered request toward the controller
//   sdram_ready, sdram_rvalid/raddress/rdata/complete : controller side inputs
//   err_bad_id   : sticky flag for a return beat with an unmapped ID
module sdram_arbiter_rr #(
    parameter int unsigned NUM_MASTERS = 5,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = $clog2(NUM_MASTERS + 1),
    parameter int unsigned RR_MODE     = 1,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_request,
    output logic [NUM_MASTERS-1:0]                m_ready,
    input  logic [NUM_MASTERS-1:0]                m_write,
    input  logic [NUM_MASTERS-1:0]                m_burst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]         m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]         m_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]     m_wstrb,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    output logic [NUM_MASTERS-1:0]                m_complete,
    output logic [ADDR_W-1:0]                     m_raddress,
    output logic [DATA_W-1:0]                     m_rdata,
    output logic [ID_W-1:0]                       sdram_request,
    input  logic                                  sdram_ready,
    output logic [ADDR_W-1:0]                     sdram_address,
    output logic                                  sdram_write,
    output logic                                  sdram_burst,
    output logic [DATA_W/8-1:0]                   sdram_wstrb,
    output logic [DATA_W-1:0]                     sdram_wdata,
    input  logic [ID_W-1:0]                       sdram_rvalid,
    input  logic [ADDR_W-1:0]                     sdram_raddress,
    input  logic [DATA_W-1:0]                     sdram_rdata,
    input  logic                                  sdram_complete,
    output logic                                  err_bad_id
);

    localparam int unsigned N      = NUM_MASTERS;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(N);
    localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

    logic [ID_W-1:0]   sdram_request_q, sdram_request_d;
    logic [ADDR_W-1:0] sdram_address_q, sdram_address_d;
    logic              sdram_write_q,   sdram_write_d;
    logic              sdram_burst_q,   sdram_burst_d;
    logic [STRB_W-1:0] sdram_wstrb_q,   sdram_wstrb_d;
    logic [DATA_W-1:0] sdram_wdata_q,   sdram_wdata_d;
    logic [PTR_W-1:0]  rr_ptr_q,        rr_ptr_d;
    logic              err_bad_id_q,    err_bad_id_d;
    logic [CNT_W-1:0]  wait_q [N];
    logic [CNT_W-1:0]  wait_d [N];

    logic [N-1:0]      starve_c;
    logic              win_valid_c;
    logic [PTR_W-1:0]  win_idx_c;
    logic [PTR_W:0]    rr_idx_c;
    logic              grant_c;
    logic [ADDR_W-1:0] addr_sel_c;
    logic [DATA_W-1:0] wdata_sel_c;
    logic [STRB_W-1:0] wstrb_sel_c;
    logic              write_sel_c;
    logic              burst_sel_c;

    // Winner selection: starvation override first, then RR or fixed priority.
    // Loops run high-to-low so the last hit (lowest index / nearest to rr_ptr) wins.
    always_comb begin
        starve_c    = '0;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        rr_idx_c    = '0;
        for (int i = 0; i < int'(N); i++) begin
            starve_c[i] = m_request[i] && (wait_q[i] >= CNT_W'(MAX_WAIT));
        end
        if (|starve_c) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (starve_c[i]) begin
                    win_valid_c = 1'b1;
                    win_idx_c   = PTR_W'(i);
                end
            end
        end else if (RR_MODE != 0) begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                rr_idx_c = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (rr_idx_c >= (PTR_W+1)'(N)) begin
                    rr_idx_c = rr_idx_c - (PTR_W+1)'(N);
                end
                if (m_request[rr_idx_c[PTR_W-1:0]]) begin
                    win_valid_c = 1'b1;
                    win_idx_c   = rr_idx_c[PTR_W-1:0];
                end
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (m_request[i]) begin
                    win_valid_c = 1'b1;
                    win_idx_c   = PTR_W'(i);
                end
            end
        end
    end

    assign grant_c = reset && sdram_ready && win_valid_c;

    // Grant strobe and payload mux for the winning master.
    always_comb begin
        m_ready     = '0;
        addr_sel_c  = '0;
        wdata_sel_c = '0;
        wstrb_sel_c = '0;
        write_sel_c = 1'b0;
        burst_sel_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (win_idx_c == PTR_W'(i)) begin
                m_ready[i]  = grant_c;
                addr_sel_c  = m_address[i*ADDR_W +: ADDR_W];
                wdata_sel_c = m_wdata[i*DATA_W +: DATA_W];
                wstrb_sel_c = m_wstrb[i*STRB_W +: STRB_W];
                write_sel_c = m_write[i];
                burst_sel_c = m_burst[i];
            end
        end
    end

    // Next-state: request register, rr pointer, starvation counters, error flag.
    always_comb begin
        sdram_request_d = sdram_request_q;
        sdram_address_d = sdram_address_q;
        sdram_write_d   = sdram_write_q;
        sdram_burst_d   = sdram_burst_q;
        sdram_wstrb_d   = sdram_wstrb_q;
        sdram_wdata_d   = sdram_wdata_q;
        rr_ptr_d        = rr_ptr_q;
        err_bad_id_d    = err_bad_id_q || (sdram_rvalid > ID_W'(N));
        for (int i = 0; i < int'(N); i++) begin
            wait_d[i] = wait_q[i];
        end

        if (sdram_ready) begin
            if (win_valid_c) begin
                sdram_request_d = ID_W'(win_idx_c) + ID_W'(1);
                sdram_address_d = addr_sel_c;
                sdram_write_d   = write_sel_c;
                sdram_burst_d   = burst_sel_c;
                sdram_wstrb_d   = wstrb_sel_c;
                sdram_wdata_d   = wdata_sel_c;
                if (RR_MODE != 0) begin
                    rr_ptr_d = (win_idx_c == PTR_W'(N - 1)) ? '0 : win_idx_c + PTR_W'(1);
                end
            end else begin
                sdram_request_d = '0;
            end
        end

        // A requesting master that loses a live arbitration ages by one.
        for (int i = 0; i < int'(N); i++) begin
            if (!m_request[i]) begin
                wait_d[i] = '0;
            end else if (sdram_ready) begin
                if (win_idx_c == PTR_W'(i)) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] < CNT_W'(MAX_WAIT)) begin
                    wait_d[i] = wait_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdram_request_q <= '0;
            sdram_address_q <= '0;
            sdram_write_q   <= 1'b0;
            sdram_burst_q   <= 1'b0;
            sdram_wstrb_q   <= '0;
            sdram_wdata_q   <= '0;
            rr_ptr_q        <= '0;
            err_bad_id_q    <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            sdram_request_q <= sdram_request_d;
            sdram_address_q <= sdram_address_d;
            sdram_write_q   <= sdram_write_d;
            sdram_burst_q   <= sdram_burst_d;
            sdram_wstrb_q   <= sdram_wstrb_d;
            sdram_wdata_q   <= sdram_wdata_d;
            rr_ptr_q        <= rr_ptr_d;
            err_bad_id_q    <= err_bad_id_d;
            for (int i = 0; i < int'(N); i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // Zero-latency return demux; unmapped IDs (0 or >N) assert nothing.
    always_comb begin
        m_rvalid   = '0;
        m_complete = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sdram_rvalid == ID_W'(i + 1)) begin
                m_rvalid[i]   = 1'b1;
                m_complete[i] = sdram_complete;
            end
        end
    end

    assign m_raddress    = sdram_raddress;
    assign m_rdata       = sdram_rdata;
    assign sdram_request = sdram_request_q;
    assign sdram_address = sdram_address_q;
    assign sdram_write   = sdram_write_q;
    assign sdram_burst   = sdram_burst_q;
    assign sdram_wstrb   = sdram_wstrb_q;
    assign sdram_wdata   = sdram_wdata_q;
    assign err_bad_id    = err_bad_id_q;

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Bench for sdram_arbiter_rr: a round-robin instance (defaults) and a
// fixed-priority instance with MAX_WAIT=3, sharing all inputs.
module tb_sdram_arbiter_rr;

    localparam int unsigned N  = 5;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 3;

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_request;
    logic [N-1:0]      m_write;
    logic [N-1:0]      m_burst;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic              sdram_ready;
    logic [IW-1:0]     sdram_rvalid;
    logic [AW-1:0]     sdram_raddress;
    logic [DW-1:0]     sdram_rdata;
    logic              sdram_complete;

    logic [N-1:0]  rr_ready, rr_rvalid, rr_complete;
    logic [AW-1:0] rr_raddress, rr_sd_address;
    logic [DW-1:0] rr_rdata, rr_sd_wdata;
    logic [IW-1:0] rr_sd_request;
    logic          rr_sd_write, rr_sd_burst, rr_err;
    logic [SW-1:0] rr_sd_wstrb;

    logic [N-1:0]  fp_ready, fp_rvalid, fp_complete;
    logic [AW-1:0] fp_raddress, fp_sd_address;
    logic [DW-1:0] fp_rdata, fp_sd_wdata;
    logic [IW-1:0] fp_sd_request;
    logic          fp_sd_write, fp_sd_burst, fp_err;
    logic [SW-1:0] fp_sd_wstrb;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter_rr #(.NUM_MASTERS(5), .ADDR_W(26), .DATA_W(32), .RR_MODE(1), .MAX_WAIT(15)) u_rr (
        .clk(clk), .reset(reset),
        .m_request(m_request), .m_ready(rr_ready), .m_write(m_write), .m_burst(m_burst),
        .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rvalid(rr_rvalid), .m_complete(rr_complete), .m_raddress(rr_raddress), .m_rdata(rr_rdata),
        .sdram_request(rr_sd_request), .sdram_ready(sdram_ready), .sdram_address(rr_sd_address),
        .sdram_write(rr_sd_write), .sdram_burst(rr_sd_burst), .sdram_wstrb(rr_sd_wstrb),
        .sdram_wdata(rr_sd_wdata), .sdram_rvalid(sdram_rvalid), .sdram_raddress(sdram_raddress),
        .sdram_rdata(sdram_rdata), .sdram_complete(sdram_complete), .err_bad_id(rr_err)
    );

    sdram_arbiter_rr #(.NUM_MASTERS(5), .ADDR_W(26), .DATA_W(32), .RR_MODE(0), .MAX_WAIT(3)) u_fp (
        .clk(clk), .reset(reset),
        .m_request(m_request), .m_ready(fp_ready), .m_write(m_write), .m_burst(m_burst),
        .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rvalid(fp_rvalid), .m_complete(fp_complete), .m_raddress(fp_raddress), .m_rdata(fp_rdata),
        .sdram_request(fp_sd_request), .sdram_ready(sdram_ready), .sdram_address(fp_sd_address),
        .sdram_write(fp_sd_write), .sdram_burst(fp_sd_burst), .sdram_wstrb(fp_sd_wstrb),
        .sdram_wdata(fp_sd_wdata), .sdram_rvalid(sdram_rvalid), .sdram_raddress(sdram_raddress),
        .sdram_rdata(sdram_rdata), .sdram_complete(sdram_complete), .err_bad_id(fp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-master payload, fixed for the whole run.
    localparam logic [N-1:0] WRITE_PAT = 5'b10101;
    localparam logic [N-1:0] BURST_PAT = 5'b01010;

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h0012_3000 + 32'(i) * 32'h111);
    endfunction
    function automatic logic [DW-1:0] wdata_of(input int i);
        return 32'hA5A5_0000 | DW'(i);
    endfunction
    function automatic logic [SW-1:0] wstrb_of(input int i);
        return SW'(i + 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Check the registered request fields against master (id-1)'s payload.
    task automatic chk_fields(input string nm, input int id);
        logic [N-1:0] wp;
        logic [N-1:0] bp;
        wp = WRITE_PAT;
        bp = BURST_PAT;
        chk({nm, "_addr"},  64'(rr_sd_address), 64'(addr_of(id - 1)));
        chk({nm, "_wdata"}, 64'(rr_sd_wdata),   64'(wdata_of(id - 1)));
        chk({nm, "_wstrb"}, 64'(rr_sd_wstrb),   64'(wstrb_of(id - 1)));
        chk({nm, "_write"}, 64'(rr_sd_write),   64'(wp[id - 1]));
        chk({nm, "_burst"}, 64'(rr_sd_burst),   64'(bp[id - 1]));
    endtask

    task automatic idle_inputs();
        m_request      = '0;
        sdram_ready    = 1'b0;
        sdram_rvalid   = '0;
        sdram_complete = 1'b0;
        sdram_raddress = '0;
        sdram_rdata    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic          rdy;
        logic [IW-1:0] rv;
        logic          cmp;
        logic [N-1:0]  exp_ready;
        logic [IW-1:0] exp_id;
        logic [N-1:0]  exp_rvalid;
        logic [N-1:0]  exp_cmp;
    } vec_t;

    vec_t vecs [12];
    logic [N-1:0] fp_exp [5];

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_write = WRITE_PAT;
        m_burst = BURST_PAT;
        for (int i = 0; i < int'(N); i++) begin
            m_address[i*AW +: AW] = addr_of(i);
            m_wdata[i*DW +: DW]   = wdata_of(i);
            m_wstrb[i*SW +: SW]   = wstrb_of(i);
        end

        // RR instance, fresh from reset (rr_ptr=0).
        vecs[0]  = '{5'b11111, 1'b1, 3'd0, 1'b0, 5'b00001, 3'd1, 5'b00000, 5'b00000};
        vecs[1]  = '{5'b11111, 1'b1, 3'd2, 1'b1, 5'b00010, 3'd2, 5'b00010, 5'b00010};
        vecs[2]  = '{5'b11111, 1'b1, 3'd5, 1'b0, 5'b00100, 3'd3, 5'b10000, 5'b00000};
        vecs[3]  = '{5'b11111, 1'b1, 3'd1, 1'b1, 5'b01000, 3'd4, 5'b00001, 5'b00001};
        vecs[4]  = '{5'b11111, 1'b1, 3'd0, 1'b1, 5'b10000, 3'd5, 5'b00000, 5'b00000};
        vecs[5]  = '{5'b11111, 1'b1, 3'd0, 1'b0, 5'b00001, 3'd1, 5'b00000, 5'b00000};
        vecs[6]  = '{5'b00000, 1'b1, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b00000, 5'b00000};
        vecs[7]  = '{5'b10100, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b00000, 5'b00000};
        vecs[8]  = '{5'b10100, 1'b1, 3'd3, 1'b1, 5'b00100, 3'd3, 5'b00100, 5'b00100};
        vecs[9]  = '{5'b10100, 1'b1, 3'd0, 1'b0, 5'b10000, 3'd5, 5'b00000, 5'b00000};
        vecs[10] = '{5'b00110, 1'b1, 3'd0, 1'b0, 5'b00010, 3'd2, 5'b00000, 5'b00000};
        vecs[11] = '{5'b01001, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd2, 5'b00000, 5'b00000};

        // Fixed priority, MAX_WAIT=3, m0 and m4 always requesting.
        fp_exp[0] = 5'b00001;
        fp_exp[1] = 5'b00001;
        fp_exp[2] = 5'b00001;
        fp_exp[3] = 5'b10000;
        fp_exp[4] = 5'b00001;

        // Reset values, and m_ready held low while in reset.
        @(negedge clk);
        reset       = 1'b0;
        m_request   = 5'b11111;
        sdram_ready = 1'b1;
        #1;
        chk("rst_m_ready", 64'(rr_ready), 64'(0));
        chk("rst_sd_req",  64'(rr_sd_request), 64'(0));
        chk("rst_sd_addr", 64'(rr_sd_address), 64'(0));
        chk("rst_sd_wdata", 64'(rr_sd_wdata), 64'(0));
        chk("rst_sd_wstrb", 64'(rr_sd_wstrb), 64'(0));
        chk("rst_sd_wb", 64'({rr_sd_write, rr_sd_burst}), 64'(0));
        chk("rst_err", 64'(rr_err), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_sd_req_held", 64'(rr_sd_request), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();

        // Single request from master 2.
        @(negedge clk);
        m_request   = 5'b00100;
        sdram_ready = 1'b1;
        #1;
        chk("t1_m_ready", 64'(rr_ready), 64'(5'b00100));
        @(posedge clk);
        #1;
        chk("t1_sd_req", 64'(rr_sd_request), 64'(3));
        chk_fields("t1", 3);

        // Table: RR ordering, idle, hold, pointer wrap, concurrent return beats.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            if (v != 0) @(negedge clk);
            m_request      = vecs[v].req;
            sdram_ready    = vecs[v].rdy;
            sdram_rvalid   = vecs[v].rv;
            sdram_complete = vecs[v].cmp;
            #1;
            chk($sformatf("v%0d_m_ready", v),    64'(rr_ready),    64'(vecs[v].exp_ready));
            chk($sformatf("v%0d_m_rvalid", v),   64'(rr_rvalid),   64'(vecs[v].exp_rvalid));
            chk($sformatf("v%0d_m_complete", v), 64'(rr_complete), 64'(vecs[v].exp_cmp));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sd_req", v), 64'(rr_sd_request), 64'(vecs[v].exp_id));
            if (vecs[v].exp_id != 0) chk_fields($sformatf("v%0d", v), int'(vecs[v].exp_id));
            if (v == 6) chk_fields("v6_hold", 1);
        end

        // Starvation override on the fixed-priority instance.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            m_request   = 5'b10001;
            sdram_ready = 1'b1;
            #1;
            chk($sformatf("fp%0d_m_ready", c), 64'(fp_ready), 64'(fp_exp[c]));
            @(posedge clk);
            #1;
        end
        chk("fp_last_sd_req", 64'(fp_sd_request), 64'(1));

        // Return demux with data.
        @(negedge clk);
        idle_inputs();
        sdram_rvalid   = 3'd2;
        sdram_complete = 1'b1;
        sdram_rdata    = 32'hDEADBEEF;
        sdram_raddress = 26'h2ABCDEF;
        #1;
        chk("t4_rvalid",   64'(rr_rvalid),   64'(5'b00010));
        chk("t4_complete", 64'(rr_complete), 64'(5'b00010));
        chk("t4_rdata",    64'(rr_rdata),    64'(32'hDEADBEEF));
        chk("t4_raddr",    64'(rr_raddress), 64'(26'h2ABCDEF));

        // Unmapped return ID sets the sticky error.
        @(negedge clk);
        sdram_rvalid = 3'd7;
        #1;
        chk("t5_rvalid",   64'(rr_rvalid),   64'(0));
        chk("t5_complete", 64'(rr_complete), 64'(0));
        chk("t5_err_pre",  64'(rr_err),      64'(0));
        @(posedge clk);
        #1;
        chk("t5_err_set", 64'(rr_err), 64'(1));
        @(negedge clk);
        sdram_rvalid   = '0;
        sdram_complete = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_err_sticky", 64'(rr_err), 64'(1));

        // Async reset between edges while a request is outstanding.
        do_reset();
        chk("t6_err_cleared", 64'(rr_err), 64'(0));
        m_request   = 5'b01000;
        sdram_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_sd_req_4", 64'(rr_sd_request), 64'(4));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_clear", 64'(rr_sd_request), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        m_request = 5'b11111;
        #1;
        chk("t6_rr_ptr0", 64'(rr_ready), 64'(5'b00001));
        @(posedge clk);
        #1;
        chk("t6_sd_req_1", 64'(rr_sd_request), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
